ddr_rd_desc_exec: RTL and testbench
===================================

// Module: ddr_rd_desc_exec
// PURPOSE
//  DDR-side executor for the 64-bit read descriptor produced by the control interface.
//  Latches the descriptor on ddr_to_mac_start, then:
//   - splits the transfer into AXI4 INCR read bursts;
//   - forwards the 512-bit read data to the MAC array;
//   - pulses ddr_to_mac_done once every beat has been delivered.
//  It sits between the control interface (ddr_user_clk domain) and the DDR AXI read port.
// PARAMETERS
//  MAX_BURST   16  max beats per AR burst (1..64, power of 2)
//  MAX_OUTST   4   max AR bursts in flight (1..15)
//  ADDR_W      32  AXI address width
// PORTS
//  ddr_user_clk        in   1    sole clock
//  ddr_user_rst        in   1    synchronous reset, active-high
//  I_cfg_value_rd_ddr  in   64   descriptor: [31:0] byte addr (64B aligned), [55:32] beats, [63:56] rsvd
//  ddr_to_mac_start    in   1    1-cycle pulse; descriptor valid this cycle
//  ddr_to_mac_done     out  1    1-cycle pulse, transfer complete
//  O_busy              out  1    high from accepted start to done
//  M_AXI_ARADDR        out  32   burst address
//  M_AXI_ARLEN         out  8    beats-1
//  M_AXI_ARVALID       out  1    AR valid
//  M_AXI_ARREADY       in   1    AR ready
//  M_AXI_RDATA         in   512  read data
//  M_AXI_RRESP         in   2    read response
//  M_AXI_RLAST         in   1    last beat of burst
//  M_AXI_RVALID        in   1    R valid
//  M_AXI_RREADY        out  1    R ready
//  O_mac_data          out  512  data to MAC
//  O_mac_valid         out  1    data valid
//  O_mac_last          out  1    final beat of whole descriptor
//  I_mac_ready         in   1    MAC accepts beat
// BEHAVIOUR
//  Reset values: every output 0; FSM IDLE; counters 0.
//  Held while ddr_user_rst=1; in-flight bursts are abandoned, and responses after release are dropped (RREADY=0 in IDLE).
//  FSM: IDLE -> (start, beats!=0) RUN -> (rx_left==0) DONE -> IDLE.
//   - IDLE: start with beats==0 goes straight to DONE. No AR is issued, and done pulses 1 cycle after start.
//   - start while busy is ignored; the descriptor is not latched.
//  RUN, AR side:
//   - issue while ar_left!=0 and outstanding<MAX_OUTST.
//   - len = min(ar_left, MAX_BURST, 64-addr[11:6]), so no burst crosses 4KB.
//   - ARADDR/ARLEN are registered and held stable while ARVALID=1 && !ARREADY.
//   - on handshake: addr += len*64, ar_left -= len, outstanding++.
//   - first ARVALID appears 1 cycle after start.
//  RUN, R side (combinational pass-through, no buffering):
//   - O_mac_data=RDATA, O_mac_valid=RVALID&busy, RREADY=I_mac_ready&busy.
//   - each R handshake: rx_left--; RLAST handshake: outstanding--.
//   - an AR handshake and an RLAST handshake in the same cycle leave outstanding unchanged.
//   - O_mac_last=1 when rx_left==1 on that beat.
//  DONE: ddr_to_mac_done=1 for exactly 1 cycle; O_busy falls in the same cycle; return to IDLE.
//  Widths: beat count 24b; address wraps modulo 2^ADDR_W (no error).
// CONFIGURATION
//  DDR_RD_RESP_CHECK_EN defined:
//   - adds output O_rd_err (1b, reset 0).
//   - set sticky on any R handshake with RRESP!=2'b00; cleared on the next accepted start.
//   - data is still forwarded.
//  Not defined: the port is absent and RRESP is ignored.
// TESTING
//  1 addr=0x1000, beats=16, ARREADY/RVALID/mac_ready=1 -> one AR (ARLEN=15), 16 beats, done 1 pulse, last on beat 16.
//  2 addr=0x0FC0, beats=3 -> AR#1 0x0FC0 ARLEN=0; AR#2 0x1000 ARLEN=1 (4KB split); done after 3 beats.
//  3 beats=40, MAX_OUTST=2, RVALID held low -> exactly 2 ARs issued, third waits until an RLAST handshake.
//  4 beats=0 -> no ARVALID; ddr_to_mac_done 1 cycle after start; O_busy never high.
//  5 I_mac_ready toggled 1/0 per cycle, beats=8 -> RREADY mirrors it, 8 beats transferred, done once.
//  6 reset asserted mid-transfer (after 5 of 32 beats) -> all outputs 0 next cycle; new start afterwards completes.
//    With DDR_RD_RESP_CHECK_EN: RRESP=2'b10 on beat 2 -> O_rd_err=1 until next start.

Source files
------------

// File: rtl/ddr_rd_desc_exec.sv
// DDR-side read descriptor executor: splits a descriptor into 4KB-safe AXI4 INCR read bursts
// and passes read beats straight to the MAC array. Optional RRESP error flag: DDR_RD_RESP_CHECK_EN.
module ddr_rd_desc_exec #(
    parameter int MAX_BURST = 16,
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              ddr_user_clk,
    input  logic              ddr_user_rst,
    input  logic [63:0]       I_cfg_value_rd_ddr,
    input  logic              ddr_to_mac_start,
    output logic              ddr_to_mac_done,
    output logic              O_busy,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [511:0]      M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic [511:0]      O_mac_data,
    output logic              O_mac_valid,
    output logic              O_mac_last,
    input  logic              I_mac_ready
`ifdef DDR_RD_RESP_CHECK_EN
    ,
    output logic              O_rd_err
`endif
);

    localparam logic [6:0] BURST_LIM = 7'(MAX_BURST);
    localparam logic [3:0] OUTST_LIM = 4'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       ar_left_q, ar_left_d;
    logic [23:0]       rx_left_q, rx_left_d;
    logic [3:0]        outst_q, outst_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;

    logic        busy;
    logic        start_acc;
    logic        ar_hs;
    logic        r_hs;
    logic        r_last_hs;
    logic        can_issue;
    logic [6:0]  len_nx;
    logic [8:0]  ar_len_cur;
    logic [23:0] desc_beats;
    logic        unused_bits;

    // Beats allowed in the next burst: bounded by what is left, MAX_BURST and the 4KB page end.
    function automatic logic [6:0] burst_len(input logic [23:0] left, input logic [5:0] blk);
        logic [6:0] to_4k;
        logic [6:0] lim;
        to_4k = 7'd64 - {1'b0, blk};
        lim   = (to_4k < BURST_LIM) ? to_4k : BURST_LIM;
        return (left < {17'd0, lim}) ? left[6:0] : lim;
    endfunction

    assign desc_beats = I_cfg_value_rd_ddr[55:32];
    assign start_acc  = ddr_to_mac_start && (state_q == S_IDLE);
    assign ar_hs      = arvalid_q && M_AXI_ARREADY;
    assign r_hs       = M_AXI_RVALID && M_AXI_RREADY;
    assign r_last_hs  = r_hs && M_AXI_RLAST;
    assign ar_len_cur = {1'b0, arlen_q} + 9'd1;

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ddr_to_mac_start) state_d = (desc_beats == 24'd0) ? S_DONE : S_RUN;
            S_RUN:  if (rx_left_d == 24'd0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_q == S_RUN);
        O_busy          = busy;
        ddr_to_mac_done = (state_q == S_DONE);
        M_AXI_RREADY    = I_mac_ready && busy;
        O_mac_valid     = M_AXI_RVALID && busy;
        O_mac_last      = M_AXI_RVALID && busy && (rx_left_q == 24'd1);
        O_mac_data      = busy ? M_AXI_RDATA : '0;
    end

    // Counters advance on handshakes; the next AR is loaded from the post-handshake view so bursts go back to back.
    always_comb begin
        addr_d    = addr_q;
        ar_left_d = ar_left_q;
        rx_left_d = rx_left_q;
        outst_d   = outst_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        if (start_acc) begin
            addr_d    = ADDR_W'(I_cfg_value_rd_ddr[31:0]);
            ar_left_d = desc_beats;
            rx_left_d = desc_beats;
            outst_d   = 4'd0;
        end else begin
            if (ar_hs) begin
                addr_d    = addr_q + ADDR_W'({ar_len_cur, 6'd0});
                ar_left_d = ar_left_q - {15'd0, ar_len_cur};
            end
            rx_left_d = rx_left_q - {23'd0, r_hs};
            outst_d   = outst_q + {3'd0, ar_hs} - {3'd0, r_last_hs};
        end
        can_issue = (start_acc || busy) && (ar_left_d != 24'd0) && (outst_d < OUTST_LIM);
        len_nx    = burst_len(ar_left_d, addr_d[11:6]);
        if (!arvalid_q || ar_hs) begin
            arvalid_d = can_issue;
            if (can_issue) begin
                araddr_d = addr_d;
                arlen_d  = {1'b0, len_nx} - 8'd1;
            end
        end
    end

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) begin
            addr_q    <= '0;
            ar_left_q <= '0;
            rx_left_q <= '0;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            ar_left_q <= ar_left_d;
            rx_left_q <= rx_left_d;
            outst_q   <= outst_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
        end
    end

    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;

`ifdef DDR_RD_RESP_CHECK_EN
    logic rd_err_q, rd_err_d;

    always_comb begin
        rd_err_d = rd_err_q;
        if (start_acc) begin
            rd_err_d = 1'b0;
        end else if (r_hs && (M_AXI_RRESP != 2'b00)) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    assign O_rd_err    = rd_err_q;
    assign unused_bits = ^I_cfg_value_rd_ddr[63:56];
`else
    assign unused_bits = ^{I_cfg_value_rd_ddr[63:56], M_AXI_RRESP};
`endif

endmodule

// File: tb/tb_ddr_rd_desc_exec.sv
// Scoreboard bench for ddr_rd_desc_exec: an AXI read-slave model feeds beats, expected ARs and
// MAC beats are queued when stimulus is driven and compared when the DUT hands them over.
module tb_ddr_rd_desc_exec;

    localparam int MAX_B = 16;
    localparam int MAX_O = 2;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } ar_t;

    typedef struct {
        logic [511:0] d;
        bit           last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  desc;
    logic         start;
    logic         done;
    logic         busy;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [511:0] mac_data;
    logic         mac_valid;
    logic         mac_last;
    logic         mac_ready;
`ifdef DDR_RD_RESP_CHECK_EN
    logic         rd_err;
`endif

    ddr_rd_desc_exec #(.MAX_BURST(MAX_B), .MAX_OUTST(MAX_O), .ADDR_W(32)) dut (
        .ddr_user_clk       (clk),
        .ddr_user_rst       (rst),
        .I_cfg_value_rd_ddr (desc),
        .ddr_to_mac_start   (start),
        .ddr_to_mac_done    (done),
        .O_busy             (busy),
        .M_AXI_ARADDR       (araddr),
        .M_AXI_ARLEN        (arlen),
        .M_AXI_ARVALID      (arvalid),
        .M_AXI_ARREADY      (arready),
        .M_AXI_RDATA        (rdata),
        .M_AXI_RRESP        (rresp),
        .M_AXI_RLAST        (rlast),
        .M_AXI_RVALID       (rvalid),
        .M_AXI_RREADY       (rready),
        .O_mac_data         (mac_data),
        .O_mac_valid        (mac_valid),
        .O_mac_last         (mac_last),
        .I_mac_ready        (mac_ready)
`ifdef DDR_RD_RESP_CHECK_EN
        ,
        .O_rd_err           (rd_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    ar_t   exp_ar_q[$];
    beat_t exp_beat_q[$];
    int    pend_q[$];

    int ar_cnt = 0, beat_cnt = 0, done_cnt = 0, outst_m = 0;
    int busy_seen = 0, arv_seen = 0;
    int desc_total = 0, desc_sent = 0;
    int done_base = 0, beat_base = 0, ar_base = 0;
    int cur_left = 0;
    bit r_pres = 0, hs_prev = 0, stall_prev = 0;
    logic [31:0] stall_addr = '0;
    logic [7:0]  stall_len = '0;
    logic [511:0] cur_data = '0;
    bit cur_last = 0;

    bit rvalid_en = 1, ready_toggle = 0, ready_on = 1, arready_rand = 0, err_inject = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference burst split: page-bounded, MAX_B-bounded, 32-bit wrapping address.
    task automatic push_ars(input logic [31:0] a, input int n);
        logic [31:0] addr;
        int left, len, to4k;
        addr = a;
        left = n;
        while (left > 0) begin
            to4k = 64 - int'(addr[11:6]);
            len  = left;
            if (len > MAX_B) len = MAX_B;
            if (len > to4k) len = to4k;
            exp_ar_q.push_back('{addr, 8'(len - 1)});
            addr = addr + 32'(len * 64);
            left -= len;
        end
    endtask

    // Slave model and monitors: drive on the falling edge, sample 1 time unit later.
    initial begin : engine
        forever begin
            @(negedge clk);
            if (hs_prev) begin
                cur_left--;
                r_pres = 0;
            end
            hs_prev = 0;
            if (!r_pres && rvalid_en) begin
                if (cur_left == 0 && pend_q.size() > 0) cur_left = pend_q.pop_front();
                if (cur_left > 0) begin
                    r_pres = 1;
                    for (int w = 0; w < 16; w++) cur_data[w*32 +: 32] = $urandom;
                    desc_sent++;
                    cur_last = (desc_sent == desc_total);
                    exp_beat_q.push_back('{cur_data, cur_last});
                end
            end
            rvalid  = r_pres;
            rdata   = cur_data;
            rlast   = r_pres && (cur_left == 1);
            rresp   = (err_inject && r_pres && desc_sent == 2) ? 2'b10 : 2'b00;
            mac_ready = ready_toggle ? !mac_ready : ready_on;
            arready = arready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall_prev) begin
                check_val("arvalid_hold", 512'(arvalid), 512'(1));
                check_val("araddr_hold", 512'(araddr), 512'(stall_addr));
                check_val("arlen_hold", 512'(arlen), 512'(stall_len));
            end
            stall_prev = arvalid && !arready;
            stall_addr = araddr;
            stall_len  = arlen;
            if (arvalid) arv_seen++;
            if (busy) begin
                busy_seen++;
                check_val("rready_mirror", 512'(rready), 512'(mac_ready));
                check_val("mac_valid_mirror", 512'(mac_valid), 512'(rvalid));
            end
            if (arvalid && arready) begin
                check_val("outst_cap", 512'(outst_m < MAX_O), 512'(1));
                if (exp_ar_q.size() == 0) begin
                    check_val("ar_unexpected", 512'(araddr), 512'(0));
                end else begin
                    ar_t e;
                    e = exp_ar_q.pop_front();
                    check_val("araddr", 512'(araddr), 512'(e.a));
                    check_val("arlen", 512'(arlen), 512'(e.l));
                end
                pend_q.push_back(int'(arlen) + 1);
                ar_cnt++;
                outst_m++;
            end
            if (rvalid && rready) begin
                hs_prev = 1;
                beat_cnt++;
                if (exp_beat_q.size() == 0) begin
                    check_val("beat_unexpected", 512'(1), 512'(0));
                end else begin
                    beat_t b;
                    b = exp_beat_q.pop_front();
                    check_val("mac_data", mac_data, b.d);
                    check_val("mac_last", 512'(mac_last), 512'(b.last));
                end
                if (rlast) outst_m--;
            end
            if (done) done_cnt++;
        end
    end

    task automatic start_desc(input logic [31:0] a, input int n);
        @(negedge clk);
        done_base  = done_cnt;
        beat_base  = beat_cnt;
        ar_base    = ar_cnt;
        desc_total = n;
        desc_sent  = 0;
        push_ars(a, n);
        desc  = {8'h5A, 24'(n), a};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic poke_start(input logic [31:0] a, input int n);
        @(negedge clk);
        desc  = {8'hC3, 24'(n), a};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done_cnt == done_base && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        check_val({tag, "_done_seen"}, 512'(done_cnt != done_base), 512'(1));
        repeat (3) @(negedge clk);
        #2;
        check_val({tag, "_done_once"}, 512'(done_cnt - done_base), 512'(1));
        check_val({tag, "_beats"}, 512'(beat_cnt - beat_base), 512'(desc_total));
        check_val({tag, "_ar_pending"}, 512'(exp_ar_q.size()), 512'(0));
        check_val({tag, "_beat_pending"}, 512'(exp_beat_q.size()), 512'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, b0, a0;
        logic [31:0] ra;
        rst = 1'b1;
        start = 1'b0;
        desc = '0;
        repeat (4) @(negedge clk);
        #2;
        check_val("rst_arvalid", 512'(arvalid), 512'(0));
        check_val("rst_araddr", 512'(araddr), 512'(0));
        check_val("rst_arlen", 512'(arlen), 512'(0));
        check_val("rst_busy", 512'(busy), 512'(0));
        check_val("rst_done", 512'(done), 512'(0));
        check_val("rst_rready", 512'(rready), 512'(0));
        check_val("rst_mac_valid", 512'(mac_valid), 512'(0));
        @(negedge clk);
        rst = 1'b0;

        start_desc(32'h0000_1000, 16);
        #2;
        check_val("t1_first_arvalid", 512'(arvalid), 512'(1));
        wait_done("t1", 200);

        start_desc(32'h0000_2000, 20);
        repeat (4) @(negedge clk);
        poke_start(32'h0000_9000, 5);
        wait_done("busy_ignore", 300);

        start_desc(32'h0000_0FC0, 3);
        wait_done("t2_4k_split", 100);

        rvalid_en = 0;
        start_desc(32'h0000_2000, 40);
        repeat (20) @(negedge clk);
        #2;
        check_val("t3_ar_capped", 512'(ar_cnt - ar_base), 512'(2));
        check_val("t3_arvalid_wait", 512'(arvalid), 512'(0));
        rvalid_en = 1;
        wait_done("t3", 400);
        check_val("t3_ar_total", 512'(ar_cnt - ar_base), 512'(3));

        b0 = busy_seen;
        a0 = arv_seen;
        start_desc(32'h0000_3000, 0);
        #2;
        check_val("t4_done_next", 512'(done), 512'(1));
        check_val("t4_busy_low", 512'(busy), 512'(0));
        wait_done("t4", 10);
        check_val("t4_busy_never", 512'(busy_seen - b0), 512'(0));
        check_val("t4_no_ar", 512'(arv_seen - a0), 512'(0));

        ready_toggle = 1;
        start_desc(32'h0000_3400, 8);
        wait_done("t5_toggle", 200);
        ready_toggle = 0;

        start_desc(32'hFFFF_FFC0, 3);
        wait_done("wrap", 100);

        arready_rand = 1;
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            ra[5:0] = 6'd0;
            start_desc(ra, $urandom_range(1, 70));
            wait_done("rand", 1500);
        end
        arready_rand = 0;

        start_desc(32'h0000_4000, 32);
        k = 0;
        while (beat_cnt - beat_base < 5 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check_val("t6_reached5", 512'(beat_cnt - beat_base), 512'(5));
        ready_on = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_val("t6_arvalid", 512'(arvalid), 512'(0));
        check_val("t6_araddr", 512'(araddr), 512'(0));
        check_val("t6_arlen", 512'(arlen), 512'(0));
        check_val("t6_busy", 512'(busy), 512'(0));
        check_val("t6_done", 512'(done), 512'(0));
        check_val("t6_rready", 512'(rready), 512'(0));
        check_val("t6_mac_valid", 512'(mac_valid), 512'(0));
        check_val("t6_mac_last", 512'(mac_last), 512'(0));
        check_val("t6_mac_data", mac_data, 512'(0));
        exp_ar_q.delete();
        exp_beat_q.delete();
        pend_q.delete();
        cur_left = 0;
        r_pres = 0;
        hs_prev = 0;
        outst_m = 0;
        rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ready_on = 1;
        start_desc(32'h0000_5000, 10);
        wait_done("t6_after", 200);

`ifdef DDR_RD_RESP_CHECK_EN
        err_inject = 1;
        start_desc(32'h0000_6000, 4);
        wait_done("err", 100);
        check_val("err_sticky", 512'(rd_err), 512'(1));
        err_inject = 0;
        start_desc(32'h0000_6100, 2);
        #2;
        check_val("err_cleared", 512'(rd_err), 512'(0));
        wait_done("err_clr", 100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
